// File: rtl/sqrt_128b_arbiter.sv
// sqrt_128b_arbiter: shares one combinational 128b floor-sqrt core among NUM_REQ valid/ready requesters.
// Define SQRT_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module sqrt_128b_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*128-1:0] req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [63:0]            resp_data,
  output logic [ID_W-1:0]        resp_id,
  output logic                   busy
);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("sqrt_128b_arbiter: SETTLE_CYCLES must be >= 1");
  end
  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("sqrt_128b_arbiter: NUM_REQ must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, COMPUTE, RESP} state_t;

  state_t            state, state_nxt;
  logic [127:0]      operand_q;
  logic [ID_W-1:0]   id_q;
  logic [CW-1:0]     cnt;
  logic [ID_W-1:0]   winner;
  logic              accept;
  logic [63:0]       root;

  // Digit-by-digit restoring square root; the core is timed as a multicycle path.
  function automatic logic [63:0] isqrt(input logic [127:0] x);
    logic [66:0] rem;
    logic [66:0] trial;
    logic [63:0] r;
    rem = '0;
    r   = '0;
    for (int i = 63; i >= 0; i--) begin
      rem   = {rem[64:0], x[2*i +: 2]};
      trial = {1'b0, r, 2'b01};
      if (rem >= trial) begin
        rem = rem - trial;
        r   = {r[62:0], 1'b1};
      end else begin
        r   = {r[62:0], 1'b0};
      end
    end
    return r;
  endfunction

  always_comb root = isqrt(operand_q);

`ifdef SQRT_ARB_RR_EN
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] cand;
  // Walk offsets from farthest to nearest so the requester just after last_grant wins.
  always_comb begin
    winner = '0;
    cand   = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = ID_W'((int'(last_grant) + i) % NUM_REQ);
      if (req_valid[cand]) winner = cand;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_grant <= ID_W'(NUM_REQ - 1);
    else if (accept) last_grant <= winner;
`else
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_valid[i]) winner = ID_W'(i);
  end
`endif

  assign accept    = rst_n && state == IDLE && |req_valid;
  assign req_ready = accept ? NUM_REQ'(1) << winner : '0;
  assign busy      = state != IDLE;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? COMPUTE : IDLE;
      COMPUTE: state_nxt = cnt == '0 ? RESP : COMPUTE;
      default: state_nxt = resp_ready ? IDLE : RESP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      operand_q  <= '0;
      id_q       <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
    end else begin
      if (accept) begin
        operand_q <= req_data[winner*128 +: 128];
        id_q      <= winner;
        cnt       <= CW'(SETTLE_CYCLES - 1);
      end
      if (state == COMPUTE) begin
        if (cnt != '0) cnt <= cnt - CW'(1);
        else begin
          resp_data  <= root;
          resp_id    <= id_q;
          resp_valid <= 1'b1;
        end
      end
      if (state == RESP && resp_ready) resp_valid <= 1'b0;
    end
endmodule

// File: tb/tb_sqrt_128b_arbiter.sv
// tb_sqrt_128b_arbiter: randomized check of sqrt_128b_arbiter against a binary-search sqrt and arbitration model.
module tb_sqrt_128b_arbiter;
  localparam int N = 4;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]     req_valid = '0, req_ready;
  logic [N*128-1:0] req_data = '0;
  logic             resp_valid, resp_ready = 1'b0, busy;
  logic [63:0]      resp_data;
  logic [1:0]       resp_id;

  logic [N-1:0]     req_valid1 = '0, req_ready1;
  logic [N*128-1:0] req_data1 = '0;
  logic             resp_valid1, resp_ready1 = 1'b0, busy1;
  logic [63:0]      resp_data1;
  logic [1:0]       resp_id1;

  sqrt_128b_arbiter #(.NUM_REQ(N), .SETTLE_CYCLES(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_id(resp_id), .busy(busy));

  sqrt_128b_arbiter #(.NUM_REQ(N), .SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_data(req_data1), .req_ready(req_ready1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_data(resp_data1), .resp_id(resp_id1), .busy(busy1));

  int n_cmp = 0;
  int n_err = 0;
  int last_g = N - 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Largest r with r*r <= x, found by bisection on [0, 2^64).
  function automatic logic [63:0] ref_sqrt(input logic [127:0] x);
    logic [64:0] lo, hi, mid;
    logic [129:0] sq;
    lo = '0;
    hi = 65'h1_0000_0000_0000_0000;
    while (hi - lo > 65'd1) begin
      mid = (lo + hi) >> 1;
      sq  = 130'(mid) * 130'(mid);
      if (sq <= 130'(x)) lo = mid;
      else hi = mid;
    end
    return lo[63:0];
  endfunction

  function automatic int pick(input logic [N-1:0] v);
`ifdef SQRT_ARB_RR_EN
    for (int off = 1; off <= N; off++)
      if (v[(last_g + off) % N]) return (last_g + off) % N;
`else
    for (int i = 0; i < N; i++)
      if (v[i]) return i;
`endif
    return -1;
  endfunction

  function automatic logic [127:0] rand128();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: return {$urandom, $urandom, $urandom, $urandom};
      1: return 128'(r) * 128'(r);
      2: return 128'(r) * 128'(r) - 128'd1;
      default: return 128'($urandom_range(0, 1000));
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < N; i++) req_data[i*128 +: 128] = rand128();
  endtask

  task automatic run_op(input logic [N-1:0] v, input int stall);
    int w, n;
    logic [63:0] e;
    req_valid = v;
    #1;
    w = pick(v);
    check("grant", 128'(req_ready), 128'(1) << w);
    check("idle_busy", 128'(busy), 0);
    e = ref_sqrt(req_data[w*128 +: 128]);
    step();
    last_g = w;
    rand_lanes();
    req_valid = N'($urandom);
    n = 0;
    while (!resp_valid && n < 3 * S + 5) begin
      check("compute_ready", 128'(req_ready), 0);
      step();
      n++;
    end
    check("latency", n, S);
    check("data", resp_data, e);
    check("id", 128'(resp_id), w);
    for (int k = 0; k < stall; k++) begin
      step();
      check("hold_valid", 128'(resp_valid), 1);
      check("hold_data", resp_data, e);
      check("hold_id", 128'(resp_id), w);
      check("hold_ready", 128'(req_ready), 0);
      check("hold_busy", 128'(busy), 1);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    req_valid = '0;
    check("hs_valid", 128'(resp_valid), 0);
    check("hs_busy", 128'(busy), 0);
    check("hs_data", resp_data, e);
  endtask

  initial begin
    int n;
    logic [N-1:0] v;
    logic [127:0] d;
    int id;
    req_valid = '1;
    #2;
    check("rst_ready", 128'(req_ready), 0);
    check("rst_valid", 128'(resp_valid), 0);
    check("rst_data", resp_data, 0);
    check("rst_id", 128'(resp_id), 0);
    check("rst_busy", 128'(busy), 0);
    req_valid = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
    // T1
    req_data[0 +: 128] = 128'd144;
    run_op(4'b0001, 0);
    // T2
    req_data[3*128 +: 128] = '1;
    run_op(4'b1000, 1);
    req_data[3*128 +: 128] = '0;
    run_op(4'b1000, 0);
    req_data[3*128 +: 128] = 128'h1_0000_0000_0000_0000;
    run_op(4'b1000, 0);
    // T3
    for (int i = 0; i < 5; i++) begin
      rand_lanes();
      run_op(4'b1111, 0);
    end
    // T4
    rand_lanes();
    run_op(4'b0110, 10);
    // random traffic
    for (int i = 0; i < 40; i++) begin
      rand_lanes();
      v = N'($urandom_range(1, (1 << N) - 1));
      run_op(v, $urandom_range(0, 3));
    end
    // T5: reset mid-COMPUTE discards the operation
    req_data[0 +: 128] = 128'd1000000;
    req_valid = 4'b0001;
    step();
    req_valid = '1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 128'(req_ready), 0);
    check("mid_rst_busy", 128'(busy), 0);
    check("mid_rst_valid", 128'(resp_valid), 0);
    check("mid_rst_data", resp_data, 0);
    check("mid_rst_id", 128'(resp_id), 0);
    last_g = N - 1;
    req_valid = '0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < S + 3; i++) begin
      step();
      check("post_rst_valid", 128'(resp_valid), 0);
    end
    req_data[0 +: 128] = 128'd81;
    run_op(4'b0001, 0);
    // T6
    req_data[0 +: 128] = 128'd10000;
    run_op(4'b0001, 0);
    // single-cycle settle instance
    for (int i = 0; i < 8; i++) begin
      id = $urandom_range(0, N - 1);
      d = rand128();
      req_data1[id*128 +: 128] = d;
      req_valid1 = N'(1) << id;
      #1;
      check("s1_grant", 128'(req_ready1), 128'(1) << id);
      step();
      req_data1[id*128 +: 128] = ~d;
      req_valid1 = '0;
      n = 0;
      while (!resp_valid1 && n < 8) begin
        step();
        n++;
      end
      check("s1_latency", n, 1);
      check("s1_data", resp_data1, ref_sqrt(d));
      check("s1_id", 128'(resp_id1), id);
      resp_ready1 = 1'b1;
      step();
      resp_ready1 = 1'b0;
      check("s1_hs_busy", 128'(busy1), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
